// File: rtl/writeback_queue.sv
// writeback_queue: merges ALU and load writebacks into an in-order FIFO draining one register-file write per cycle
module writeback_queue #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        alu_valid,
  input  logic [4:0]  alu_wsel,
  input  logic [31:0] alu_wdat,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_wsel,
  input  logic [31:0] mem_wdat,
  output logic        mem_ready,
  output logic        rf_WEN,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  input  logic [4:0]  chk_sel1,
  input  logic [4:0]  chk_sel2,
  output logic        chk_hit1,
  output logic        chk_hit2,
  output logic        empty
);
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEFT = (AW+1)'(DEPTH - 1);

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, mem_slot;
  logic [4:0]    wsel_q [DEPTH];
  logic [31:0]   wdat_q [DEPTH];
  logic          rf_wen_q, rf_wen_d;
  logic [4:0]    rf_wsel_q, rf_wsel_d;
  logic [31:0]   rf_wdat_q, rf_wdat_d;
  logic          pop, alu_push, mem_push;

  // Admission from registered occupancy only; the last free slot goes to the ALU when it asks
  always_comb begin
    alu_ready = count_q != FULL;
    mem_ready = (count_q < ONE_LEFT) || (count_q == ONE_LEFT && !alu_valid);
    alu_push  = alu_valid && alu_ready && alu_wsel != 5'd0;
    mem_push  = mem_valid && mem_ready && mem_wsel != 5'd0;
    pop       = count_q != '0;
    mem_slot  = wr_ptr_q + AW'(alu_push);
    count_d   = count_q - (AW+1)'(pop) + (AW+1)'(alu_push) + (AW+1)'(mem_push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    wr_ptr_d  = mem_slot + AW'(mem_push);
    rf_wen_d  = pop;
    rf_wsel_d = pop ? wsel_q[rd_ptr_q] : rf_wsel_q;
    rf_wdat_d = pop ? wdat_q[rd_ptr_q] : rf_wdat_q;
  end

  // Pending lookup over live FIFO slots plus the write currently on the port; r0 never hits
  always_comb begin
    chk_hit1 = rf_wen_q && rf_wsel_q == chk_sel1;
    chk_hit2 = rf_wen_q && rf_wsel_q == chk_sel2;
    for (int i = 0; i < DEPTH; i++) begin
      chk_hit1 |= ({1'b0, AW'(i) - rd_ptr_q} < count_q) && wsel_q[i] == chk_sel1;
      chk_hit2 |= ({1'b0, AW'(i) - rd_ptr_q} < count_q) && wsel_q[i] == chk_sel2;
    end
    chk_hit1 &= chk_sel1 != 5'd0;
    chk_hit2 &= chk_sel2 != 5'd0;
  end

  // Occupancy, pointers and the registered write port; reset drops everything in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rf_wen_q  <= 1'b0;
      rf_wsel_q <= '0;
      rf_wdat_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rf_wen_q  <= rf_wen_d;
      rf_wsel_q <= rf_wsel_d;
      rf_wdat_q <= rf_wdat_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides which slots are live; ALU entry is older
  always_ff @(posedge CLK) begin
    if (alu_push) begin
      wsel_q[wr_ptr_q] <= alu_wsel;
      wdat_q[wr_ptr_q] <= alu_wdat;
    end
    if (mem_push) begin
      wsel_q[mem_slot] <= mem_wsel;
      wdat_q[mem_slot] <= mem_wdat;
    end
  end

  assign rf_WEN  = rf_wen_q;
  assign rf_wsel = rf_wsel_q;
  assign rf_wdat = rf_wdat_q;
  assign empty   = count_q == '0 && !rf_wen_q;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST)
    !(count_q == FULL && (alu_push || mem_push)));
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: vector table plus directed fill/backpressure and mid-drain reset sequences
module tb_writeback_queue;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_wsel = '0, mem_wsel = '0, chk_sel1 = '0, chk_sel2 = '0;
  logic [31:0] alu_wdat = '0, mem_wdat = '0;
  logic        alu_ready, mem_ready, rf_WEN, chk_hit1, chk_hit2, empty;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  int          checks = 0, errors = 0;

  writeback_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .alu_valid(alu_valid), .alu_wsel(alu_wsel), .alu_wdat(alu_wdat), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_wsel(mem_wsel), .mem_wdat(mem_wdat), .mem_ready(mem_ready),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .chk_sel1(chk_sel1), .chk_sel2(chk_sel2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .empty(empty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic av; logic [4:0] aw; logic [31:0] ad;
    logic mv; logic [4:0] mw; logic [31:0] md;
    logic [4:0] s1, s2;
    logic ar, mr, wen; logic [4:0] ws; logic [31:0] wd; logic h1, h2, emp;
  } vec_t;

  vec_t v[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int ai, mi, mc;
    logic ear, emr, a_acc, m_acc;
    logic [36:0] expq[$];
    logic [36:0] w;
    //             av aw ad            mv mw md        s1 s2  ar mr wen ws wd           h1 h2 emp
    v[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1};
    v[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1};
    v[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0};
    v[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    v[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    v[5]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    v[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    v[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h11,       1'b1, 1'b0, 1'b0};
    v[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 32'h22,       1'b1, 1'b1, 1'b0};
    v[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22,       1'b0, 1'b0, 1'b1};
    v[10] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22,       1'b0, 1'b0, 1'b1};
    v[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22,       1'b0, 1'b0, 1'b1};
    v[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22,       1'b0, 1'b0, 1'b1};

    // Reset state, then idle with every lookup index
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_wen", rf_WEN, 0);
    chk("rst_wsel", rf_wsel, 0);
    chk("rst_wdat", rf_wdat, 0);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    chk("idle_empty", empty, 1);
    chk("idle_alu_ready", alu_ready, 1);
    chk("idle_mem_ready", mem_ready, 1);
    for (int s = 0; s < 32; s++) begin
      chk_sel1 = 5'(s);
      chk_sel2 = 5'(31 - s);
      #1;
      chk("idle_hit1", chk_hit1, 0);
      chk("idle_hit2", chk_hit2, 0);
    end

    // Table: single write, simultaneous sources to r3, register 0
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      alu_valid = v[i].av; alu_wsel = v[i].aw; alu_wdat = v[i].ad;
      mem_valid = v[i].mv; mem_wsel = v[i].mw; mem_wdat = v[i].md;
      chk_sel1 = v[i].s1; chk_sel2 = v[i].s2;
      #1;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, v[i].ar);
      chk($sformatf("v%0d_mem_ready", i), mem_ready, v[i].mr);
      chk($sformatf("v%0d_wen", i), rf_WEN, v[i].wen);
      chk($sformatf("v%0d_wsel", i), rf_wsel, v[i].ws);
      chk($sformatf("v%0d_wdat", i), rf_wdat, v[i].wd);
      chk($sformatf("v%0d_hit1", i), chk_hit1, v[i].h1);
      chk($sformatf("v%0d_hit2", i), chk_hit2, v[i].h2);
      chk($sformatf("v%0d_empty", i), empty, v[i].emp);
    end

    // Fill and backpressure: both producers hold requests until accepted
    ai = 0; mi = 0; mc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      alu_valid = ai < 6; alu_wsel = 5'(10 + ai); alu_wdat = 32'(32'hA0 + ai);
      mem_valid = mi < 6; mem_wsel = 5'(20 + mi); mem_wdat = 32'(32'hB0 + mi);
      #1;
      ear = mc < 4;
      emr = mc <= 2 || (mc == 3 && !alu_valid);
      chk("fill_alu_ready", alu_ready, ear);
      chk("fill_mem_ready", mem_ready, emr);
      if (rf_WEN) begin
        if (expq.size() == 0) chk("fill_spurious_wen", rf_WEN, 0);
        else begin
          w = expq.pop_front();
          chk("fill_order_wsel", rf_wsel, w[36:32]);
          chk("fill_order_wdat", rf_wdat, w[31:0]);
        end
      end
      a_acc = alu_valid && ear;
      m_acc = mem_valid && emr;
      mc = mc - (mc > 0 ? 1 : 0) + (a_acc ? 1 : 0) + (m_acc ? 1 : 0);
      if (a_acc) begin expq.push_back({alu_wsel, alu_wdat}); ai++; end
      if (m_acc) begin expq.push_back({mem_wsel, mem_wdat}); mi++; end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("fill_all_alu_taken", 32'(ai), 6);
    chk("fill_all_mem_taken", 32'(mi), 6);
    chk("fill_all_drained", 32'(expq.size()), 0);
    chk("fill_empty", empty, 1);

    // Mid-drain reset: three entries queued, one write on the port
    @(negedge CLK);
    alu_valid = 1'b1; alu_wsel = 5'd7; alu_wdat = 32'h70;
    mem_valid = 1'b1; mem_wsel = 5'd8; mem_wdat = 32'h80;
    @(negedge CLK);
    alu_wsel = 5'd9; alu_wdat = 32'h90;
    mem_wsel = 5'd10; mem_wdat = 32'hA0;
    @(negedge CLK);
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk_sel1 = 5'd9; chk_sel2 = 5'd10;
    #1;
    chk("pre_rst_wen", rf_WEN, 1);
    chk("pre_rst_wsel", rf_wsel, 7);
    chk("pre_rst_hit1", chk_hit1, 1);
    chk("pre_rst_hit2", chk_hit2, 1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_wen", rf_WEN, 0);
    chk("mid_rst_wsel", rf_wsel, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_hit1", chk_hit1, 0);
    chk("mid_rst_hit2", chk_hit2, 0);
    #1;
    nRST = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      #1;
      chk("post_rst_wen", rf_WEN, 0);
      chk("post_rst_empty", empty, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
